// File: rtl/u_hzd_pkg.sv
// Shared types and default sizing for the integer-pipeline hazard/flush controller.
// No logic; the scoreboard and the controller both import it.
package u_pkg;

    typedef struct packed {
        logic       v;
        logic [4:0] a;
    } sb_entry_t;

    typedef enum logic {S_RUN, S_FLUSH} hzd_state_t;

    localparam int HZD_DEPTH     = 4;
    localparam int HZD_FLUSH_CYC = 2;

endpackage

// File: rtl/u_hzd_sb.sv
// In-flight destination scoreboard: DEPTH-deep shift register, one new entry per cycle.
// Matches are combinational; an entry ages out on the edge its regfile write lands.
module u_hzd_sb
    import u_pkg::*;
#(
    parameter int DEPTH = HZD_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  sb_entry_t   push,
    input  logic [4:0]  rs1_a,
    input  logic [4:0]  rs2_a,
    output logic        match1,
    output logic        match2,
    output logic [31:0] busy
);

    sb_entry_t   r_slot [DEPTH];
    logic [31:0] w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            r_slot[0] <= push;
            for (int i = 1; i < DEPTH; i++) begin
                r_slot[i] <= r_slot[i-1];
            end
        end
    end

    // x0 is never entered as valid, but keep bit 0 hard-zero regardless.
    always_comb begin
        w_busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_slot[i].v) begin
                w_busy[r_slot[i].a] = 1'b1;
            end
        end
        w_busy[0] = 1'b0;
    end

    assign busy   = w_busy;
    assign match1 = w_busy[rs1_a];
    assign match2 = w_busy[rs2_a];

endmodule

// File: rtl/u_hzd.sv
// RAW stall and taken-branch flush sequencing for the in-order integer pipeline.
// All outputs combinational from state and decode inputs; decode holds while stall is high.
module u_hzd
    import u_pkg::*;
#(
    parameter int DEPTH     = HZD_DEPTH,
    parameter int FLUSH_CYC = HZD_FLUSH_CYC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1_a,
    input  logic [4:0]  id_rs2_a,
    input  logic        id_rs1_use,
    input  logic        id_rs2_use,
    input  logic [4:0]  id_rd_a,
    input  logic        id_rd_we,
    input  logic        exe_branch,
    output logic        stall,
    output logic        flush0,
    output logic        flush1,
    output logic [31:0] busy
);

    localparam int FCW = (FLUSH_CYC > 2) ? $clog2(FLUSH_CYC - 1) : 1;

    hzd_state_t     r_state;
    logic [FCW-1:0] r_fcnt;

    logic        w_match1;
    logic        w_match2;
    logic [31:0] w_busy;
    logic        w_hazard;
    logic        w_flush1;
    logic        w_stall;
    sb_entry_t   w_push;

    u_hzd_sb #(
        .DEPTH (DEPTH)
    ) u_sb (
        .clk    (clk),
        .rst    (rst),
        .push   (w_push),
        .rs1_a  (id_rs1_a),
        .rs2_a  (id_rs2_a),
        .match1 (w_match1),
        .match2 (w_match2),
        .busy   (w_busy)
    );

    assign w_hazard = (id_rs1_use & (id_rs1_a != 5'd0) & w_match1)
                    | (id_rs2_use & (id_rs2_a != 5'd0) & w_match2);

    // A flush wins over a hazard: the wrong-path instruction is neither stalled nor pushed.
    assign w_flush1 = exe_branch | (r_state == S_FLUSH);
    assign w_stall  = id_valid & w_hazard & ~w_flush1;

    assign w_push.v = id_valid & ~w_stall & ~w_flush1 & id_rd_we & (id_rd_a != 5'd0);
    assign w_push.a = (id_valid & ~w_stall & ~w_flush1) ? id_rd_a : 5'd0;

    // The branch cycle itself is the first squash cycle, so the counter covers the rest.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
            r_fcnt  <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (exe_branch && (FLUSH_CYC > 1)) begin
                        r_state <= S_FLUSH;
                        r_fcnt  <= FCW'(FLUSH_CYC - 2);
                    end
                end
                S_FLUSH: begin
                    if (r_fcnt == '0) begin
                        r_state <= S_RUN;
                    end else begin
                        r_fcnt <= r_fcnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_RUN;
                    r_fcnt  <= '0;
                end
            endcase
        end
    end

    assign stall  = ~rst & w_stall;
    assign flush1 = ~rst & w_flush1;
    assign flush0 = ~rst & (w_stall | w_flush1);
    assign busy   = rst ? 32'd0 : w_busy;

endmodule

// File: tb/tb_u_hzd.sv
module tb_u_hzd;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1_a;
    logic [4:0]  id_rs2_a;
    logic        id_rs1_use;
    logic        id_rs2_use;
    logic [4:0]  id_rd_a;
    logic        id_rd_we;
    logic        exe_branch;
    logic        stall;
    logic        flush0;
    logic        flush1;
    logic [31:0] busy;

    logic [34:0] q_exp [$];
    string       q_tag [$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    u_hzd dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs1_a   (id_rs1_a),
        .id_rs2_a   (id_rs2_a),
        .id_rs1_use (id_rs1_use),
        .id_rs2_use (id_rs2_use),
        .id_rd_a    (id_rd_a),
        .id_rd_we   (id_rd_we),
        .exe_branch (exe_branch),
        .stall      (stall),
        .flush0     (flush0),
        .flush1     (flush1),
        .busy       (busy)
    );

    // One cycle: drive inputs just after the edge, queue the expected outputs,
    // compare mid-cycle, then advance to the next rising edge.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic we, input logic br,
                        input logic es, input logic ef0, input logic ef1,
                        input logic [31:0] eb);
        logic [34:0] obs;
        logic [34:0] exp_v;
        string       t;
        rst        = r;
        id_valid   = v;
        id_rs1_a   = rs1;
        id_rs1_use = u1;
        id_rs2_a   = rs2;
        id_rs2_use = u2;
        id_rd_a    = rd;
        id_rd_we   = we;
        exe_branch = br;
        q_exp.push_back({es, ef0, ef1, eb});
        q_tag.push_back(tag);
        #2;
        obs   = {stall, flush0, flush1, busy};
        exp_v = q_exp.pop_front();
        t     = q_tag.pop_front();
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed stall/f0/f1/busy=%b/%b/%b/%h expected %b/%b/%b/%h",
                   t, obs[34], obs[33], obs[32], obs[31:0],
                   exp_v[34], exp_v[33], exp_v[32], exp_v[31:0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [31:0] eb);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eb);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset with live valid and branch: everything gated to zero.
        step("rst_c0", 1, 1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 1, 0, 0, 0, 32'h0);
        step("rst_c1", 1, 1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 1, 0, 0, 0, 32'h0);
        idle("post_rst", 32'h0);

        // RAW: addi x5 then add x6,x5,x5.
        step("raw_prod", 0, 1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 4; i++)
            step("raw_stall", 0, 1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 1, 1, 0, 32'h20);
        step("raw_issue", 0, 1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 4; i++) idle("raw_busy6", 32'h40);
        idle("raw_drain", 32'h0);

        // x0 producer/consumer and unused sources.
        step("x0_prod", 0, 1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 0, 0, 32'h0);
        step("x0_cons", 0, 1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0, 0, 0, 32'h0);
        step("x7_prod", 0, 1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0, 0, 0, 32'h0);
        step("x7_unused", 0, 1, 5'd7, 0, 5'd7, 0, 5'd0, 0, 0, 0, 0, 0, 32'h80);
        for (int i = 0; i < 3; i++) idle("x7_busy", 32'h80);
        idle("x7_drain", 32'h0);

        // Taken branch with a wrong-path rd=9 write in decode.
        step("br_t0", 0, 1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 1, 0, 1, 1, 32'h0);
        step("br_t1", 0, 1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 0, 0, 1, 1, 32'h0);
        step("br_resume", 0, 1, 5'd0, 0, 5'd0, 0, 5'd10, 1, 0, 0, 0, 0, 32'h0);
        // Branch together with a hazard on x10; a second branch in S_FLUSH is ignored.
        step("brhz_t0", 0, 1, 5'd10, 1, 5'd0, 0, 5'd11, 1, 1, 0, 1, 1, 32'h400);
        step("brhz_t1", 0, 1, 5'd10, 1, 5'd0, 0, 5'd11, 1, 1, 0, 1, 1, 32'h400);
        step("brhz_stall0", 0, 1, 5'd10, 1, 5'd0, 0, 5'd0, 0, 0, 1, 1, 0, 32'h400);
        step("brhz_stall1", 0, 1, 5'd10, 1, 5'd0, 0, 5'd0, 0, 0, 1, 1, 0, 32'h400);
        step("brhz_issue", 0, 1, 5'd10, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 32'h0);

        // Reset in the second stall cycle of a RAW pair.
        step("rms_prod", 0, 1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0, 0, 0, 32'h0);
        step("rms_stall", 0, 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 1, 1, 0, 32'h20);
        step("rms_rst", 1, 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0, 0, 32'h0);
        step("rms_issue", 0, 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0, 0, 32'h0);
        idle("rms_busy6", 32'h40);

        // Reset mid-flush aborts the squash window.
        step("rmf_br", 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 1, 1, 32'h40);
        step("rmf_rst", 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 32'h0);
        idle("rmf_run", 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1);
    end

endmodule
